// File: rtl/accel_fifo_manager_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accel_fifo_manager_pkg
//  Description : Shared FSM encoding, axis codes and default sizes for the
//                accelerometer FIFO manager.
//  Revision    : 1.0 - initial release
// ============================================================================
package accel_fifo_manager_pkg;

    localparam int DEPTH_DEFAULT  = 16;
    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_WAIT_X = 2'd0,
        ST_WAIT_Y = 2'd1,
        ST_WAIT_Z = 2'd2
    } asm_state_e;

    // Remaining-word count at Load names the axis being delivered.
    localparam logic [1:0] AXIS_X   = 2'd2;
    localparam logic [1:0] AXIS_Y   = 2'd1;
    localparam logic [1:0] AXIS_Z   = 2'd0;
    localparam logic [1:0] AXIS_BAD = 2'd3;

endpackage : accel_fifo_manager_pkg
`default_nettype wire

// File: rtl/accel_fifo_manager_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered read data and level count.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     rd_valid_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    logic w_empty;
    logic w_full;
    logic w_do_rd;
    logic w_do_wr;

    assign w_empty = (level_q == '0);
    assign w_full  = (level_q == FULL_LVL);
    assign w_do_rd = rd_en_i & ~w_empty;
    // A pop in the same cycle frees the slot the write lands in.
    assign w_do_wr = wr_en_i & (~w_full | w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= w_do_rd;
            if (w_do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_do_rd) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q];
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign empty_o    = w_empty;
    assign full_o     = w_full;
    assign level_o    = level_q;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/accel_fifo_manager.sv
`default_nettype none
// ============================================================================
//  Module      : accel_fifo_manager
//  Description : Assembles X/Y/Z words from the SPI wrapper into triples,
//                queues them, and forwards single-register read bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module accel_fifo_manager
    import accel_fifo_manager_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Load,
    input  logic [DATA_W-1:0]        MISO_Data,
    input  logic [1:0]               i_Byte_Count,
    input  logic                     axis_mode,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_x,
    output logic [DATA_W-1:0]        rd_y,
    output logic [DATA_W-1:0]        rd_z,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               reg_data,
    output logic                     reg_valid,
    output logic                     overflow,
    output logic                     seq_err
);

    localparam int TW = 3 * DATA_W;

    asm_state_e        state_q, state_d;
    logic [DATA_W-1:0] x_hold_q;
    logic [DATA_W-1:0] y_hold_q;
    logic [7:0]        reg_data_q;
    logic              reg_valid_q;
    logic              overflow_q;
    logic              seq_err_q;

    logic              w_axis_load;
    logic              w_cap_x;
    logic              w_cap_y;
    logic              w_commit;
    logic              w_seq_bad;
    logic [TW-1:0]     w_rd_data;
    logic              w_full;

    assign w_axis_load = Load & axis_mode;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT_X;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leaving axis mode abandons any partial triple silently.
    always_comb begin
        state_d = state_q;
        if (!axis_mode) begin
            state_d = ST_WAIT_X;
        end else if (Load) begin
            case (state_q)
                ST_WAIT_X: begin
                    if (i_Byte_Count == AXIS_X) state_d = ST_WAIT_Y;
                end
                ST_WAIT_Y: begin
                    if (i_Byte_Count == AXIS_Y)      state_d = ST_WAIT_Z;
                    else if (i_Byte_Count != AXIS_X) state_d = ST_WAIT_X;
                end
                ST_WAIT_Z: begin
                    if (i_Byte_Count == AXIS_X) state_d = ST_WAIT_Y;
                    else                        state_d = ST_WAIT_X;
                end
                default: state_d = ST_WAIT_X;
            endcase
        end
    end

    // Outputs of the assembler: capture strobes, commit, sequence fault
    always_comb begin
        w_cap_x   = 1'b0;
        w_cap_y   = 1'b0;
        w_commit  = 1'b0;
        w_seq_bad = 1'b0;
        if (w_axis_load) begin
            case (state_q)
                ST_WAIT_X: begin
                    if (i_Byte_Count == AXIS_X) w_cap_x   = 1'b1;
                    else                        w_seq_bad = 1'b1;
                end
                ST_WAIT_Y: begin
                    if (i_Byte_Count == AXIS_Y) begin
                        w_cap_y = 1'b1;
                    end else begin
                        w_seq_bad = 1'b1;
                        w_cap_x   = (i_Byte_Count == AXIS_X);
                    end
                end
                ST_WAIT_Z: begin
                    if (i_Byte_Count == AXIS_Z) begin
                        w_commit = 1'b1;
                    end else begin
                        w_seq_bad = 1'b1;
                        w_cap_x   = (i_Byte_Count == AXIS_X);
                    end
                end
                default: w_seq_bad = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_hold_q    <= '0;
            y_hold_q    <= '0;
            reg_data_q  <= '0;
            reg_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            if (w_cap_x) x_hold_q <= MISO_Data;
            if (w_cap_y) y_hold_q <= MISO_Data;
            reg_valid_q <= Load & ~axis_mode;
            if (Load && !axis_mode) begin
                reg_data_q <= MISO_Data[7:0];
            end
            // A full FIFO only refuses the triple when nothing is popped alongside.
            if (w_commit && w_full && !rd_en) begin
                overflow_q <= 1'b1;
            end
            if (w_seq_bad) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (w_commit),
        .wr_data_i  ({x_hold_q, y_hold_q, MISO_Data}),
        .rd_en_i    (rd_en),
        .rd_data_o  (w_rd_data),
        .rd_valid_o (rd_valid),
        .empty_o    (empty),
        .full_o     (w_full),
        .level_o    (level)
    );

    assign full      = w_full;
    assign rd_x      = w_rd_data[TW-1:2*DATA_W];
    assign rd_y      = w_rd_data[2*DATA_W-1:DATA_W];
    assign rd_z      = w_rd_data[DATA_W-1:0];
    assign reg_data  = reg_data_q;
    assign reg_valid = reg_valid_q;
    assign overflow  = overflow_q;
    assign seq_err   = seq_err_q;

endmodule : accel_fifo_manager
`default_nettype wire

// File: tb/tb_accel_fifo_manager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accel_fifo_manager
//  Description : Scoreboard bench for accel_fifo_manager.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_fifo_manager;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 16;
    localparam logic [1:0] BX = 2'd2, BY = 2'd1, BZ = 2'd0, BB = 2'd3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              Load = 1'b0;
    logic [DATA_W-1:0] MISO_Data = '0;
    logic [1:0]        i_Byte_Count = '0;
    logic              axis_mode = 1'b1;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_x, rd_y, rd_z;
    logic              rd_valid, empty, full, reg_valid, overflow, seq_err;
    logic [4:0]        level;
    logic [7:0]        reg_data;

    accel_fifo_manager #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .Load(Load), .MISO_Data(MISO_Data),
        .i_Byte_Count(i_Byte_Count), .axis_mode(axis_mode), .rd_en(rd_en),
        .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z), .rd_valid(rd_valid),
        .empty(empty), .full(full), .level(level), .reg_data(reg_data),
        .reg_valid(reg_valid), .overflow(overflow), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [47:0] mdl_q[$];   // triples the bench believes are stored
    logic [47:0] sb_q[$];    // triples expected to appear on rd_x/y/z
    logic [7:0]  reg_q[$];   // bytes expected on reg_data

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented output against the scoreboard
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rd_valid", {rd_x, rd_y, rd_z}, 64'hDEAD);
            end else begin
                check("rd_triple", {rd_x, rd_y, rd_z}, sb_q.pop_front());
            end
        end
        if (reg_valid) begin
            if (reg_q.size() == 0) begin
                check("unexpected_reg_valid", reg_data, 64'hDEAD);
            end else begin
                check("reg_data", reg_data, reg_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        Load  = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mdl_q.delete();
    endtask

    task automatic axis_load(input logic [1:0] bc, input logic [15:0] d);
        Load = 1'b1; i_Byte_Count = bc; MISO_Data = d;
        step();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        if (mdl_q.size() > 0) sb_q.push_back(mdl_q.pop_front());
        step();
    endtask

    task automatic commit(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] z, input logic rd);
        axis_load(BX, x);
        axis_load(BY, y);
        Load = 1'b1; i_Byte_Count = BZ; MISO_Data = z; rd_en = rd;
        if (rd && mdl_q.size() > 0) sb_q.push_back(mdl_q.pop_front());
        if (mdl_q.size() < DEPTH) mdl_q.push_back({x, y, z});
        step();
    endtask

    task automatic drain_wait();
        for (int i = 0; i < 40 && sb_q.size() > 0; i++) step();
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset overrides Load and rd_en in the same cycle
        step();
        rst = 1'b1; Load = 1'b1; i_Byte_Count = BX; MISO_Data = 16'h1111; rd_en = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_rd_xyz", {rd_x, rd_y, rd_z, rd_valid}, 0);
        check("rst_reg", {reg_data, reg_valid}, 0);
        check("rst_flags", {overflow, seq_err}, 0);

        // Basic triple round trip
        commit(16'h1234, 16'h5678, 16'h9ABC, 1'b0);
        check("one_level", level, 1);
        pop();
        check("pop_empty", empty, 1);
        check("pop_valid", rd_valid, 1);
        step();

        // Register-read path and read-while-empty
        axis_mode = 1'b0;
        Load = 1'b1; MISO_Data = 16'h00E5; reg_q.push_back(8'hE5);
        step();
        check("reg_valid_pulse", reg_valid, 1);
        check("reg_level", level, 0);
        rd_en = 1'b1;
        step();
        check("empty_rd_valid", rd_valid, 0);
        check("empty_rd_hold", {rd_x, rd_y, rd_z}, 48'h1234_5678_9ABC);
        axis_mode = 1'b1;

        // Skipped Y is a sequence error with no commit
        axis_load(BX, 16'hAAAA);
        axis_load(BZ, 16'hBBBB);
        check("skip_seq_err", seq_err, 1);
        check("skip_level", level, 0);
        commit(16'h0101, 16'h0202, 16'h0303, 1'b0);
        check("recover_level", level, 1);
        pop();
        drain_wait();

        // Fill to full, overflow on the 17th, drain in order
        check("pre_overflow", overflow, 0);
        for (int i = 1; i <= DEPTH; i++)
            commit(16'(16'h1000 + i), 16'(16'h2000 + i), 16'(16'h3000 + i), 1'b0);
        check("fill_full", full, 1);
        check("fill_level", level, 16);
        commit(16'h1011, 16'h2011, 16'h3011, 1'b0);
        check("ovf_flag", overflow, 1);
        check("ovf_level", level, 16);
        for (int i = 0; i < DEPTH; i++) pop();
        drain_wait();
        check("drained_empty", empty, 1);

        // Full FIFO with commit and pop together
        do_reset();
        for (int i = 1; i <= DEPTH; i++)
            commit(16'(16'h4000 + i), 16'(16'h5000 + i), 16'(16'h6000 + i), 1'b0);
        commit(16'h7777, 16'h8888, 16'h9999, 1'b1);
        check("fullrw_overflow", overflow, 0);
        check("fullrw_level", level, 16);
        for (int i = 0; i < DEPTH; i++) pop();
        drain_wait();

        // Leaving axis mode mid-triple discards it without a sequence error
        do_reset();
        axis_load(BX, 16'hDEAD);
        axis_load(BY, 16'hBEEF);
        axis_mode = 1'b0;
        step();
        axis_mode = 1'b1;
        commit(16'hC0C0, 16'hD0D0, 16'hE0E0, 1'b0);
        check("abort_no_seq_err", seq_err, 0);
        check("abort_level", level, 1);
        pop();
        drain_wait();

        // Reset mid-triple discards staged words
        do_reset();
        axis_load(BX, 16'h0A0A);
        axis_load(BY, 16'h0B0B);
        do_reset();
        axis_load(BZ, 16'h0C0C);
        check("rst_mid_seq_err", seq_err, 1);
        check("rst_mid_level", level, 0);
        check("rst_mid_state", {empty, full, overflow, rd_valid, reg_valid}, 5'b10000);
        check("rst_mid_rd", {rd_x, rd_y, rd_z, reg_data}, 0);
        axis_load(BB, 16'h0D0D);
        check("bad_code_level", level, 0);
        step();
        check("reg_sb_drained", reg_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_accel_fifo_manager
`default_nettype wire
